// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM states, the next-PC select from Decode,
// and the instruction width in bytes.
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      VALID,
      FAULT
   } fetch_state_e;

   typedef enum logic {
      NEXTPC,
      OFFSET
   } pc_mux_e;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over req/gnt/rvalid,
// and holds the instruction for Decode until it retires.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_op,
   output logic [31:0] imem_addr_op,
   input  logic        imem_gnt_ip,
   input  logic        imem_rvalid_ip,
   input  logic [31:0] imem_rdata_ip,
   output logic        instr_data_valid_op,
   output logic [31:0] instr_data_op,
   output logic [31:0] pc_op,
   output logic [31:0] pc4_op,
   input  logic        instr_retire_ip,
   input  pc_mux_e     pc_mux_ip,
   input  logic [31:0] pc_branch_offset_ip,
   output logic        fetch_fault_op,
   output logic [31:0] instr_count_op
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q;
   logic [31:0]  instr_q;
   logic [31:0]  count_q;
   logic [31:0]  nextPc;

   // A misaligned target parks the block in FAULT with the bad target kept in the PC.
   always_comb begin
      state_d = state_q;
      nextPc  = (pc_mux_ip == OFFSET) ? (pc_q + pc_branch_offset_ip) : (pc_q + INSTR_BYTES);
      case (state_q)
         IDLE:    state_d = REQ;
         REQ:     if (imem_gnt_ip) state_d = WAIT;
         WAIT:    if (imem_rvalid_ip) state_d = VALID;
         VALID:   if (instr_retire_ip) state_d = (nextPc[1:0] != 2'b00) ? FAULT : REQ;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= BOOT_ADDR;
         instr_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WAIT && imem_rvalid_ip) begin
            instr_q <= imem_rdata_ip;
         end
         if (state_q == VALID && instr_retire_ip) begin
            pc_q    <= nextPc;
            count_q <= count_q + 32'd1;
         end
      end
   end

   assign imem_req_op         = (state_q == REQ);
   assign imem_addr_op        = pc_q;
   assign instr_data_valid_op = (state_q == VALID);
   assign instr_data_op       = instr_q;
   assign pc_op               = pc_q;
   assign pc4_op              = pc_q + INSTR_BYTES;
   assign fetch_fault_op      = (state_q == FAULT);
   assign instr_count_op      = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level PC/count model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_op;
   logic [31:0] imem_addr_op;
   logic        imem_gnt_ip;
   logic        imem_rvalid_ip;
   logic [31:0] imem_rdata_ip;
   logic        instr_data_valid_op;
   logic [31:0] instr_data_op;
   logic [31:0] pc_op;
   logic [31:0] pc4_op;
   logic        instr_retire_ip;
   pc_mux_e     pc_mux_ip;
   logic [31:0] pc_branch_offset_ip;
   logic        fetch_fault_op;
   logic [31:0] instr_count_op;

   int total = 0;
   int bad   = 0;

   logic [31:0] mPc;
   logic [31:0] mCount;
   logic [31:0] mInstr;
   bit          mFault;

   fetch_unit #(.BOOT_ADDR(32'h0000_0000)) dut (
      .clock              (clock),
      .reset              (reset),
      .imem_req_op        (imem_req_op),
      .imem_addr_op       (imem_addr_op),
      .imem_gnt_ip        (imem_gnt_ip),
      .imem_rvalid_ip     (imem_rvalid_ip),
      .imem_rdata_ip      (imem_rdata_ip),
      .instr_data_valid_op(instr_data_valid_op),
      .instr_data_op      (instr_data_op),
      .pc_op              (pc_op),
      .pc4_op             (pc4_op),
      .instr_retire_ip    (instr_retire_ip),
      .pc_mux_ip          (pc_mux_ip),
      .pc_branch_offset_ip(pc_branch_offset_ip),
      .fetch_fault_op     (fetch_fault_op),
      .instr_count_op     (instr_count_op)
   );

   always #5 clock = ~clock;

   // Inputs change and outputs are sampled on the falling edge, half a cycle clear of the active edge.
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idleInputs();
      imem_gnt_ip         = 1'b0;
      imem_rvalid_ip      = 1'b0;
      imem_rdata_ip       = 32'h0;
      instr_retire_ip     = 1'b0;
      pc_mux_ip           = NEXTPC;
      pc_branch_offset_ip = 32'h0;
   endtask

   task automatic checkRequesting(input string tag);
      checkOutput({tag, "_req"}, 32'(imem_req_op), 32'd1);
      checkOutput({tag, "_addr"}, imem_addr_op, mPc);
      checkOutput({tag, "_valid"}, 32'(instr_data_valid_op), 32'd0);
      checkOutput({tag, "_fault"}, 32'(fetch_fault_op), 32'd0);
   endtask

   task automatic applyReset(input int cycles);
      idleInputs();
      reset = 1'b0;
      repeat (cycles) begin
         tick();
         checkOutput("rst_req", 32'(imem_req_op), 32'd0);
         checkOutput("rst_addr", imem_addr_op, 32'h0);
         checkOutput("rst_valid", 32'(instr_data_valid_op), 32'd0);
         checkOutput("rst_instr", instr_data_op, 32'h0);
         checkOutput("rst_fault", 32'(fetch_fault_op), 32'd0);
         checkOutput("rst_count", instr_count_op, 32'h0);
      end
      reset  = 1'b1;
      mPc    = 32'h0;
      mCount = 32'h0;
      mFault = 1'b0;
   endtask

   // One fetch transaction from REQ to VALID; noise on ignored inputs is injected while waiting.
   task automatic applyStimulus(input logic [31:0] word, input int gntDelay, input int rvDelay,
                                input bit sameCycle);
      checkRequesting("fetch");
      repeat (gntDelay) begin
         imem_rvalid_ip  = 1'($urandom_range(0, 1));
         imem_rdata_ip   = $urandom;
         instr_retire_ip = 1'($urandom_range(0, 1));
         tick();
         checkRequesting("fetch_hold");
      end
      imem_gnt_ip     = 1'b1;
      imem_rvalid_ip  = sameCycle;
      imem_rdata_ip   = ~word;
      instr_retire_ip = 1'b0;
      tick();
      imem_gnt_ip    = 1'b0;
      imem_rvalid_ip = 1'b0;
      checkOutput("wait_req", 32'(imem_req_op), 32'd0);
      checkOutput("wait_valid", 32'(instr_data_valid_op), 32'd0);
      repeat (rvDelay) begin
         imem_gnt_ip     = 1'($urandom_range(0, 1));
         instr_retire_ip = 1'($urandom_range(0, 1));
         tick();
         checkOutput("wait_hold_req", 32'(imem_req_op), 32'd0);
         checkOutput("wait_hold_valid", 32'(instr_data_valid_op), 32'd0);
      end
      imem_gnt_ip     = 1'b0;
      instr_retire_ip = 1'b0;
      imem_rvalid_ip  = 1'b1;
      imem_rdata_ip   = word;
      tick();
      imem_rvalid_ip = 1'b0;
      imem_rdata_ip  = $urandom;
      mInstr = word;
      checkOutput("valid", 32'(instr_data_valid_op), 32'd1);
      checkOutput("instr", instr_data_op, mInstr);
      checkOutput("pc", pc_op, mPc);
      checkOutput("pc4", pc4_op, mPc + 32'd4);
      checkOutput("count", instr_count_op, mCount);
      checkOutput("valid_req", 32'(imem_req_op), 32'd0);
   endtask

   // Retire the presented instruction after some hold cycles, then check the redirect against the model.
   task automatic retire(input pc_mux_e mux, input logic [31:0] offset, input int holdCycles);
      logic [31:0] target;
      repeat (holdCycles) begin
         imem_gnt_ip         = 1'($urandom_range(0, 1));
         imem_rvalid_ip      = 1'($urandom_range(0, 1));
         pc_mux_ip           = pc_mux_e'($urandom_range(0, 1));
         pc_branch_offset_ip = $urandom;
         tick();
         checkOutput("hold_valid", 32'(instr_data_valid_op), 32'd1);
         checkOutput("hold_instr", instr_data_op, mInstr);
         checkOutput("hold_pc", pc_op, mPc);
      end
      idleInputs();
      instr_retire_ip     = 1'b1;
      pc_mux_ip           = mux;
      pc_branch_offset_ip = offset;
      tick();
      idleInputs();
      target = (mux == OFFSET) ? (mPc + offset) : (mPc + 32'd4);
      mCount = mCount + 32'd1;
      mPc    = target;
      mFault = (target % 4) != 0;
      checkOutput("ret_valid", 32'(instr_data_valid_op), 32'd0);
      checkOutput("ret_count", instr_count_op, mCount);
      checkOutput("ret_fault", 32'(fetch_fault_op), 32'(mFault));
      if (mFault) begin
         checkOutput("ret_fault_req", 32'(imem_req_op), 32'd0);
         checkOutput("ret_fault_pc", pc_op, mPc);
      end else begin
         checkRequesting("ret");
      end
   endtask

   // Directed scenarios first, then a randomized run, then fault and reset recovery.
   initial begin
      idleInputs();
      reset = 1'b0;

      applyReset(2);
      tick();
      checkRequesting("boot");

      applyStimulus(32'h00A0_0093, 2, 0, 1'b0);
      retire(NEXTPC, 32'h0, 1);
      checkOutput("t2_addr", imem_addr_op, 32'h4);

      applyStimulus($urandom, 0, 1, 1'b0);
      retire(OFFSET, 32'h0000_000C, 0);
      checkOutput("t3_pc10", imem_addr_op, 32'h10);
      applyStimulus($urandom, 0, 0, 1'b1);
      retire(OFFSET, 32'hFFFF_FFF8, 2);
      checkOutput("t3_addr8", imem_addr_op, 32'h08);

      applyStimulus($urandom, 1, 2, 1'b1);
      retire(OFFSET, 32'hFFFF_FFF4, 0);
      checkOutput("t4_top", imem_addr_op, 32'hFFFF_FFFC);
      applyStimulus($urandom, 0, 0, 1'b0);
      retire(NEXTPC, 32'h0000_0002, 1);
      checkOutput("t4_wrap", imem_addr_op, 32'h0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
         retire(pc_mux_e'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
      end

      applyStimulus($urandom, 0, 0, 1'b0);
      retire(OFFSET, 32'h0000_0002, 0);
      for (int i = 0; i < 6; i++) begin
         imem_gnt_ip     = 1'($urandom_range(0, 1));
         imem_rvalid_ip  = 1'($urandom_range(0, 1));
         instr_retire_ip = 1'($urandom_range(0, 1));
         tick();
         checkOutput("fault_sticky", 32'(fetch_fault_op), 32'd1);
         checkOutput("fault_noreq", 32'(imem_req_op), 32'd0);
         checkOutput("fault_novalid", 32'(instr_data_valid_op), 32'd0);
         checkOutput("fault_count", instr_count_op, mCount);
      end

      applyReset(1);
      tick();
      checkRequesting("post_fault");
      checkOutput("post_fault_count", instr_count_op, 32'h0);

      applyStimulus($urandom, 0, 0, 1'b0);
      retire(NEXTPC, 32'h0, 0);
      imem_gnt_ip = 1'b1;
      tick();
      imem_gnt_ip = 1'b0;
      applyReset(2);
      imem_rvalid_ip = 1'b1;
      imem_rdata_ip  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid_ip = 1'b0;
      checkRequesting("stray");
      checkOutput("stray_count", instr_count_op, 32'h0);
      applyStimulus(32'h1234_5678, 1, 1, 1'b0);
      retire(NEXTPC, 32'h0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
